// File: rtl/cw_trig_capture.sv
// Capture/trigger engine for the on-chip watcher: per-bus masked trigger modes,
// pre-trigger window, post-trigger length and circular trace-RAM addressing.
module cw_trig_capture #(
    parameter int BUS_NUM    = 2,
    parameter int BUS_WIDTH  = 16,
    parameter int ADDR_WIDTH = 10
) (
    input  logic                         trig_clk,
    input  logic                         trig_rst,
    input  logic [BUS_NUM*BUS_WIDTH-1:0] bus_din,
    input  logic                         sample_en,
    input  logic [BUS_NUM*BUS_WIDTH-1:0] cfg_value,
    input  logic [BUS_NUM*BUS_WIDTH-1:0] cfg_mask,
    input  logic [2*BUS_NUM-1:0]         cfg_mode,
    input  logic                         cfg_or,
    input  logic [ADDR_WIDTH-1:0]        cfg_pre_len,
    input  logic [ADDR_WIDTH-1:0]        cfg_post_len,
    input  logic                         arm,
    input  logic                         abort,
    output logic                         wt_ce,
    output logic                         wt_en,
    output logic [ADDR_WIDTH-1:0]        wt_addr,
    output logic [BUS_NUM*BUS_WIDTH-1:0] wt_data,
    output logic                         busy,
    output logic                         triggered,
    output logic                         done,
    output logic [ADDR_WIDTH-1:0]        trig_addr
);

    typedef enum logic [1:0] {S_IDLE, S_ARMED, S_POST, S_DONE} state_t;

    state_t                         state;
    logic [ADDR_WIDTH-1:0]          wptr;
    logic [ADDR_WIDTH-1:0]          pre_cnt;
    logic [ADDR_WIDTH-1:0]          post_cnt;
    logic [BUS_NUM*BUS_WIDTH-1:0]   prev;
    logic                           prev_valid;
    logic                           fin;
    logic [BUS_NUM-1:0]             hit;
    logic [BUS_NUM-1:0]             bus_on;
    logic                           cond;

    for (genvar g = 0; g < BUS_NUM; g++) begin : g_bus
        logic [BUS_WIDTH-1:0] d, p, m, v;
        logic [1:0]           mode;
        assign d    = bus_din[g*BUS_WIDTH +: BUS_WIDTH];
        assign p    = prev[g*BUS_WIDTH +: BUS_WIDTH];
        assign m    = cfg_mask[g*BUS_WIDTH +: BUS_WIDTH];
        assign v    = cfg_value[g*BUS_WIDTH +: BUS_WIDTH];
        assign mode = cfg_mode[2*g +: 2];
        assign bus_on[g] = |mode;
        assign hit[g] = (mode == 2'b01) ? ((d & m) == (v & m)) :
                        (mode == 2'b10) ? (prev_valid && |(~p & d & m)) :
                        (mode == 2'b11) ? (prev_valid && |((p ^ d) & m)) : 1'b1;
    end

    always_comb begin
        cond = 1'b1;
        if (|bus_on)
            cond = cfg_or ? |(hit & bus_on) : &(hit | ~bus_on);
    end

    assign wt_ce = (state == S_ARMED) || (state == S_POST);
    assign busy  = wt_ce;

    // The final write is held one cycle in ARMED/POST (fin) so wt_ce still
    // covers it; DONE follows on the next edge.
    always_ff @(posedge trig_clk) begin
        if (trig_rst) begin
            state      <= S_IDLE;
            wptr       <= '0;
            pre_cnt    <= '0;
            post_cnt   <= '0;
            prev       <= '0;
            prev_valid <= 1'b0;
            fin        <= 1'b0;
            wt_en      <= 1'b0;
            wt_addr    <= '0;
            wt_data    <= '0;
            triggered  <= 1'b0;
            done       <= 1'b0;
            trig_addr  <= '0;
        end else begin
            wt_en <= 1'b0;
            case (state)
                S_IDLE, S_DONE: begin
                    if (arm && !abort) begin
                        state      <= S_ARMED;
                        triggered  <= 1'b0;
                        done       <= 1'b0;
                        wptr       <= '0;
                        pre_cnt    <= '0;
                        prev_valid <= 1'b0;
                        fin        <= 1'b0;
                    end
                end
                default: begin
                    if (abort) begin
                        state <= S_IDLE;
                        fin   <= 1'b0;
                    end else if (fin) begin
                        state <= S_DONE;
                        done  <= 1'b1;
                        fin   <= 1'b0;
                    end else if (sample_en) begin
                        wt_en      <= 1'b1;
                        wt_addr    <= wptr;
                        wt_data    <= bus_din;
                        wptr       <= wptr + ADDR_WIDTH'(1);
                        prev       <= bus_din;
                        prev_valid <= 1'b1;
                        if (pre_cnt != '1)
                            pre_cnt <= pre_cnt + ADDR_WIDTH'(1);
                        if (state == S_ARMED) begin
                            if (cond && (pre_cnt >= cfg_pre_len)) begin
                                state     <= S_POST;
                                trig_addr <= wptr;
                                triggered <= 1'b1;
                                post_cnt  <= cfg_post_len;
                                fin       <= (cfg_post_len == '0);
                            end
                        end else begin
                            post_cnt <= post_cnt - ADDR_WIDTH'(1);
                            if (post_cnt == ADDR_WIDTH'(1))
                                fin <= 1'b1;
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cw_trig_capture.sv
// Bench for cw_trig_capture: directed scenarios plus random traffic, checked
// every cycle against a queue-based model of the stored trace.
module tb_cw_trig_capture;

    localparam int BN = 2;
    localparam int BW = 16;
    localparam int AW = 4;
    localparam int DEPTH = 1 << AW;

    logic              trig_clk = 1'b0;
    logic              trig_rst;
    logic [BN*BW-1:0]  bus_din;
    logic              sample_en;
    logic [BN*BW-1:0]  cfg_value;
    logic [BN*BW-1:0]  cfg_mask;
    logic [2*BN-1:0]   cfg_mode;
    logic              cfg_or;
    logic [AW-1:0]     cfg_pre_len;
    logic [AW-1:0]     cfg_post_len;
    logic              arm;
    logic              abort;
    logic              wt_ce;
    logic              wt_en;
    logic [AW-1:0]     wt_addr;
    logic [BN*BW-1:0]  wt_data;
    logic              busy;
    logic              triggered;
    logic              done;
    logic [AW-1:0]     trig_addr;

    cw_trig_capture #(.BUS_NUM(BN), .BUS_WIDTH(BW), .ADDR_WIDTH(AW)) dut (
        .trig_clk(trig_clk), .trig_rst(trig_rst), .bus_din(bus_din),
        .sample_en(sample_en), .cfg_value(cfg_value), .cfg_mask(cfg_mask),
        .cfg_mode(cfg_mode), .cfg_or(cfg_or), .cfg_pre_len(cfg_pre_len),
        .cfg_post_len(cfg_post_len), .arm(arm), .abort(abort),
        .wt_ce(wt_ce), .wt_en(wt_en), .wt_addr(wt_addr), .wt_data(wt_data),
        .busy(busy), .triggered(triggered), .done(done), .trig_addr(trig_addr)
    );

    always #5 trig_clk = ~trig_clk;

    int total = 0;
    int bad = 0;

    // phase: 0 idle, 1 capturing, 2 done
    int               m_phase;
    logic [BN*BW-1:0] stored[$];
    int               trig_idx;
    bit               m_fin;
    bit               m_en;
    logic [BN*BW-1:0] m_data;
    int               m_addr;
    int               m_taddr;
    bit               m_trig;
    bit               m_done;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic bit model_cond(input logic [BN*BW-1:0] d);
        bit any_on = 0;
        bit all_hit = 1;
        bit one_hit = 0;
        logic [BN*BW-1:0] last;
        last = (stored.size() > 0) ? stored[stored.size()-1] : '0;
        for (int b = 0; b < BN; b++) begin
            logic [BW-1:0] dv, pv, mv, vv;
            bit h;
            dv = d[b*BW +: BW];
            pv = last[b*BW +: BW];
            mv = cfg_mask[b*BW +: BW];
            vv = cfg_value[b*BW +: BW];
            case (cfg_mode[2*b +: 2])
                2'b01: h = ((dv & mv) == (vv & mv));
                2'b10: h = (stored.size() > 0) && ((~pv & dv & mv) != 0);
                2'b11: h = (stored.size() > 0) && (((pv ^ dv) & mv) != 0);
                default: h = 1;
            endcase
            if (cfg_mode[2*b +: 2] != 2'b00) begin
                any_on = 1;
                all_hit = all_hit & h;
                one_hit = one_hit | h;
            end
        end
        if (!any_on) return 1;
        return cfg_or ? one_hit : all_hit;
    endfunction

    task automatic model_edge();
        int n;
        bit c;
        if (trig_rst) begin
            m_phase = 0; stored.delete(); trig_idx = -1; m_fin = 0; m_en = 0;
            m_data = '0; m_addr = 0; m_taddr = 0; m_trig = 0; m_done = 0;
            return;
        end
        m_en = 0;
        if (m_phase != 1) begin
            if (arm && !abort) begin
                m_phase = 1; stored.delete(); trig_idx = -1; m_fin = 0;
                m_trig = 0; m_done = 0;
            end
        end else if (abort) begin
            m_phase = 0; m_fin = 0;
        end else if (m_fin) begin
            m_phase = 2; m_done = 1; m_fin = 0;
        end else if (sample_en) begin
            n = stored.size();
            c = model_cond(bus_din);
            m_en = 1; m_data = bus_din; m_addr = n % DEPTH;
            if (trig_idx < 0 && c && (((n > DEPTH-1) ? DEPTH-1 : n) >= int'(cfg_pre_len))) begin
                trig_idx = n; m_taddr = n % DEPTH; m_trig = 1;
            end
            stored.push_back(bus_din);
            if (trig_idx >= 0 && (stored.size() - 1 - trig_idx) == int'(cfg_post_len))
                m_fin = 1;
        end
    endtask

    task automatic check_all();
        check("wt_ce", 64'(wt_ce), 64'(m_phase == 1));
        check("busy", 64'(busy), 64'(m_phase == 1));
        check("wt_en", 64'(wt_en), 64'(m_en));
        check("wt_addr", 64'(wt_addr), 64'(m_addr));
        check("wt_data", 64'(wt_data), 64'(m_data));
        check("triggered", 64'(triggered), 64'(m_trig));
        check("done", 64'(done), 64'(m_done));
        check("trig_addr", 64'(trig_addr), 64'(m_taddr));
    endtask

    task automatic step();
        @(posedge trig_clk);
        model_edge();
        #1;
        check_all();
    endtask

    task automatic set_cfg(input logic [15:0] v0, input logic [15:0] mk0, input logic [1:0] md0,
                           input logic [15:0] v1, input logic [15:0] mk1, input logic [1:0] md1,
                           input logic orr, input int pre, input int post);
        cfg_value = {v1, v0};
        cfg_mask = {mk1, mk0};
        cfg_mode = {md1, md0};
        cfg_or = orr;
        cfg_pre_len = AW'(pre);
        cfg_post_len = AW'(post);
    endtask

    task automatic do_arm();
        arm = 1; step(); arm = 0;
    endtask

    task automatic do_abort();
        abort = 1; step(); abort = 0;
    endtask

    task automatic run_seq(input int n);
        for (int i = 0; i < n; i++) begin
            bus_din = {16'h0000, 16'(16'h00A0 + i)};
            step();
        end
    endtask

    initial begin
        trig_rst = 1; bus_din = '0; sample_en = 1; arm = 0; abort = 0;
        set_cfg(16'h00A5, 16'hFFFF, 2'b01, 16'h0, 16'h0, 2'b00, 0, 3, 4);
        step(); step();
        check("rst_wt_addr", 64'(wt_addr), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        trig_rst = 0;
        step();

        // equal trigger
        do_arm();
        run_seq(12);
        check("eq_trig_addr", 64'(trig_addr), 64'd5);
        check("eq_last_addr", 64'(wt_addr), 64'd9);
        check("eq_done", 64'(done), 64'd1);
        check("eq_ce_low", 64'(wt_ce), 64'd0);

        // pre-window blocks early match
        set_cfg(16'h00A1, 16'hFFFF, 2'b01, 16'h0, 16'h0, 2'b00, 0, 3, 4);
        do_arm();
        run_seq(20);
        check("pre_no_trig", 64'(triggered), 64'd0);
        check("pre_busy", 64'(busy), 64'd1);
        do_abort();
        check("pre_abort_idle", 64'(busy), 64'd0);
        set_cfg(16'h00A3, 16'hFFFF, 2'b01, 16'h0, 16'h0, 2'b00, 0, 3, 4);
        do_arm();
        run_seq(12);
        check("pre_trig_addr", 64'(trig_addr), 64'd3);

        // wrap-around
        set_cfg(16'h00B4, 16'hFFFF, 2'b01, 16'h0, 16'h0, 2'b00, 0, 2, 5);
        do_arm();
        run_seq(30);
        check("wrap_trig_addr", 64'(trig_addr), 64'd4);
        check("wrap_last_addr", 64'(wt_addr), 64'd9);
        check("wrap_done", 64'(done), 64'd1);

        // qualifier + rising edge on bus1 bit0
        set_cfg(16'h0, 16'h0, 2'b00, 16'h0, 16'h0001, 2'b10, 0, 0, 2);
        do_arm();
        for (int c = 0; c < 24; c++) begin
            int q;
            q = c / 2;
            sample_en = (c % 2 == 0);
            if (sample_en)
                bus_din = {16'((q == 0 || q >= 4) ? 1 : 0), 16'(q)};
            else
                bus_din = {16'($urandom), 16'($urandom)};
            step();
            if (c == 1) check("edge_no_first", 64'(triggered), 64'd0);
        end
        sample_en = 1;
        check("edge_trig_addr", 64'(trig_addr), 64'd4);
        check("edge_done", 64'(done), 64'd1);

        // arm+abort collision, abort in POST, arm in DONE
        arm = 1; abort = 1; step(); arm = 0; abort = 0;
        check("coll_idle", 64'(busy), 64'd0);
        set_cfg(16'h00A2, 16'hFFFF, 2'b01, 16'h0, 16'h0, 2'b00, 0, 0, 8);
        do_arm();
        run_seq(5);
        do_abort();
        check("abort_idle", 64'(busy), 64'd0);
        check("abort_done", 64'(done), 64'd0);
        check("abort_trig", 64'(triggered), 64'd1);
        check("abort_no_wr", 64'(wt_en), 64'd0);
        set_cfg(16'h00A2, 16'hFFFF, 2'b01, 16'h0, 16'h0, 2'b00, 0, 0, 1);
        do_arm();
        run_seq(6);
        check("done_set", 64'(done), 64'd1);
        do_arm();
        check("rearm_done", 64'(done), 64'd0);
        run_seq(1);
        check("rearm_addr0", 64'(wt_addr), 64'd0);
        check("rearm_wr", 64'(wt_en), 64'd1);

        // reset mid-POST, then repeat the equal trigger
        set_cfg(16'h00A5, 16'hFFFF, 2'b01, 16'h0, 16'h0, 2'b00, 0, 3, 4);
        do_abort();
        do_arm();
        run_seq(7);
        trig_rst = 1; step(); trig_rst = 0;
        check("mid_rst_trig", 64'(triggered), 64'd0);
        check("mid_rst_taddr", 64'(trig_addr), 64'd0);
        check("mid_rst_ce", 64'(wt_ce), 64'd0);
        do_arm();
        run_seq(12);
        check("after_rst_taddr", 64'(trig_addr), 64'd5);
        check("after_rst_done", 64'(done), 64'd1);

        // random traffic
        for (int c = 0; c < 3000; c++) begin
            if (m_phase != 1 && $urandom_range(0, 7) == 0)
                set_cfg(16'($urandom_range(0, 3)), 16'($urandom) | 16'h0003, 2'($urandom_range(0, 3)),
                        16'($urandom_range(0, 3)), 16'($urandom) | 16'h0003, 2'($urandom_range(0, 3)),
                        1'($urandom_range(0, 1)), $urandom_range(0, 7), $urandom_range(0, 7));
            arm = ($urandom_range(0, 11) == 0);
            abort = ($urandom_range(0, 59) == 0);
            trig_rst = ($urandom_range(0, 299) == 0);
            sample_en = ($urandom_range(0, 3) != 0);
            bus_din = {16'($urandom_range(0, 3)), 16'($urandom_range(0, 3))};
            if ($urandom_range(0, 9) == 0) bus_din = $urandom;
            step();
        end
        arm = 0; abort = 0; trig_rst = 0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
